// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the dual-clock Gray-pointer FIFO.
//
//   Contents:
//     ptr_word_t    - 32-bit carrier type used by the Gray helpers, so that
//                     one function serves every pointer width. Callers
//                     zero-extend into it and truncate the result back.
//     DEFAULT_DEPTH - default FIFO depth in words.
//     calc_abits()  - address width for a given power-of-two depth.
//     bin2gray()    - binary to reflected Gray code.
//     gray2bin()    - reflected Gray code back to binary.
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef logic [31:0] ptr_word_t;

  localparam int DEFAULT_DEPTH = 512;

  // Address bits needed to index a power-of-two depth.
  function automatic int calc_abits(input int depth);
    return $clog2(depth);
  endfunction

  // Zero-extended inputs convert correctly, because the upper zero bits
  // contribute nothing to either transform.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// ---------------------------------------------------------------------------
// gray_ptr_sync
//   Multi-flop synchroniser for a Gray-coded pointer. It also converts the
//   synchronised value back to binary. The top instantiates it once per
//   crossing direction. A third instance with ABITS = 0 (one bit) serves as
//   the read-side reset synchroniser.
//
//   Parameters:
//     ABITS       - pointer is ABITS+1 bits wide
//     SYNC_STAGES - number of flops in the chain (2 or more)
//
//   Ports:
//     clock    in   destination-domain clock
//     reset    in   synchronous active-high clear of the chain
//     gray_in  in   Gray pointer from the source domain
//     gray_out out  synchronised Gray pointer (last chain stage)
//     bin_out  out  binary form of gray_out (combinational decode)
// ---------------------------------------------------------------------------
module gray_ptr_sync
  import fifo_pkg::*;
#(
  parameter int ABITS       = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [ABITS:0] gray_in,
  output logic [ABITS:0] gray_out,
  output logic [ABITS:0] bin_out
);

  localparam int PW = ABITS + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];

  // Shift the source value down the chain. Only one bit of a Gray pointer
  // changes per source edge, so any stage that goes metastable settles to
  // either the old pointer or the new one.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_d[i];
    end
  end

  assign gray_out = sync_q[SYNC_STAGES-1];
  assign bin_out  = PW'(gray2bin(ptr_word_t'(sync_q[SYNC_STAGES-1])));

endmodule

// File: rtl/fifo_gray_async.sv
// ---------------------------------------------------------------------------
// fifo_gray_async
//   Dual-clock FIFO between the protocol engines (in_clock) and the host/MCU
//   interface (out_clock). Pointers cross domains as Gray code. Both sides
//   report a conservative fill level, threshold flags and sticky
//   overflow/underflow flags. Every flag is registered.
//
//   Build option:
//     FIFO_FWFT_EN - when defined, the FIFO runs in first-word fall-through
//                    mode: out_data presents the head word while out_nempty
//                    is high. When undefined, out_data updates on the edge
//                    after an accepted pop and holds its value otherwise.
//
//   Parameters: WIDTH, DEPTH (power of two, >= 4), AFULL_THRESH,
//               AEMPTY_THRESH, SYNC_STAGES (>= 2)
//
//   Write side (in_clock):
//     reset           in   synchronous active-high, sampled on in_clock
//     in_shift        in   write request
//     in_data         in   write data
//     in_full         out  FIFO full; a write is refused
//     in_almost_full  out  in_level >= AFULL_THRESH
//     in_level        out  words stored as seen by the writer (may over-report)
//     in_overflow     out  sticky: a write was attempted while full
//   Read side (out_clock):
//     out_pop          in   read request
//     out_data         out  read data
//     out_nempty       out  a word is available
//     out_almost_empty out  out_level <= AEMPTY_THRESH
//     out_level        out  words stored as seen by the reader (may under-report)
//     out_underflow    out  sticky: a pop was attempted while empty
// ---------------------------------------------------------------------------
module fifo_gray_async
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     in_clock,
  input  logic                     reset,
  input  logic                     out_clock,
  input  logic                     in_shift,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_full,
  output logic                     in_almost_full,
  output logic [$clog2(DEPTH):0]   in_level,
  output logic                     in_overflow,
  input  logic                     out_pop,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_nempty,
  output logic                     out_almost_empty,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic                     out_underflow
);

  localparam int ABITS = calc_abits(DEPTH);
  localparam int PW    = ABITS + 1;

  // Dual-port storage: one write port on in_clock, one synchronous read
  // port on out_clock. It is never reset.
  logic [WIDTH-1:0] ram [DEPTH];

  // -------------------------------------------------------------------------
  // Write-side state
  // -------------------------------------------------------------------------
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          in_full_q, in_full_d;
  logic          in_almost_full_q, in_almost_full_d;
  logic [PW-1:0] in_level_q, in_level_d;
  logic          in_overflow_q, in_overflow_d;
  logic          write_en;
  logic [PW-1:0] rgray_sync;
  logic [PW-1:0] rptr_sync;

  // -------------------------------------------------------------------------
  // Read-side state
  // -------------------------------------------------------------------------
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    rgray_q, rgray_d;
  logic             out_nempty_q, out_nempty_d;
  logic             out_almost_empty_q, out_almost_empty_d;
  logic [PW-1:0]    out_level_q, out_level_d;
  logic             out_underflow_q, out_underflow_d;
  logic [WIDTH-1:0] out_data_q;
  logic             pop_ok;
  logic [PW-1:0]    wgray_sync;
  logic [PW-1:0]    wptr_sync;
  logic             out_reset;
  logic [0:0]       rst_sync_gray;
  logic [0:0]       rst_sync_bin;
  logic [ABITS-1:0] rd_addr;
  logic             rd_en;

  // Read pointer into the write domain, reset with the write side.
  gray_ptr_sync #(
    .ABITS      (ABITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rptr_sync (
    .clock   (in_clock),
    .reset   (reset),
    .gray_in (rgray_q),
    .gray_out(rgray_sync),
    .bin_out (rptr_sync)
  );

  // Write pointer into the read domain, reset by the synchronised reset.
  gray_ptr_sync #(
    .ABITS      (ABITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wptr_sync (
    .clock   (out_clock),
    .reset   (out_reset),
    .gray_in (wgray_q),
    .gray_out(wgray_sync),
    .bin_out (wptr_sync)
  );

  // Single-bit chain that carries reset into out_clock. The chain is never
  // cleared itself. Holding reset for a few slow-clock cycles flushes it.
  gray_ptr_sync #(
    .ABITS      (0),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clock   (out_clock),
    .reset   (1'b0),
    .gray_in (reset),
    .gray_out(rst_sync_gray),
    .bin_out (rst_sync_bin)
  );

  // For a single bit the Gray and binary outputs are identical.
  assign out_reset = rst_sync_gray[0] & rst_sync_bin[0];

  // Write side. Full and almost-full are computed from the next pointer,
  // so they rise on the same edge as the write that causes them. Full
  // compares Gray codes: the FIFO is full when the two top bits differ and
  // all remaining bits are equal.
  always_comb begin
    write_en         = in_shift && !in_full_q;
    wptr_d           = wptr_q + PW'(write_en);
    wgray_d          = PW'(bin2gray(ptr_word_t'(wptr_d)));
    in_full_d        = (wgray_d == {~rgray_sync[ABITS:ABITS-1], rgray_sync[ABITS-2:0]});
    in_level_d       = wptr_d - rptr_sync;
    in_almost_full_d = (in_level_d >= PW'(AFULL_THRESH));
    in_overflow_d    = in_overflow_q | (in_shift & in_full_q);
    if (reset) begin
      write_en         = 1'b0;
      wptr_d           = '0;
      wgray_d          = '0;
      in_full_d        = 1'b0;
      in_level_d       = '0;
      in_almost_full_d = 1'b0;
      in_overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge in_clock) begin
    wptr_q           <= wptr_d;
    wgray_q          <= wgray_d;
    in_full_q        <= in_full_d;
    in_almost_full_q <= in_almost_full_d;
    in_level_q       <= in_level_d;
    in_overflow_q    <= in_overflow_d;
  end

  always_ff @(posedge in_clock) begin
    if (write_en) begin
      ram[wptr_q[ABITS-1:0]] <= in_data;
    end
  end

  // Read side. The reader sees a write only after the synchroniser, so
  // the slot it reads has always settled. Empty compares the next Gray read
  // pointer with the synchronised write pointer, so out_nempty falls on the
  // edge of the pop that empties the FIFO.
  always_comb begin
    pop_ok             = out_pop && out_nempty_q;
    rptr_d             = rptr_q + PW'(pop_ok);
    rgray_d            = PW'(bin2gray(ptr_word_t'(rptr_d)));
    out_nempty_d       = (rgray_d != wgray_sync);
    out_level_d        = wptr_sync - rptr_d;
    out_almost_empty_d = (out_level_d <= PW'(AEMPTY_THRESH));
    out_underflow_d    = out_underflow_q | (out_pop & ~out_nempty_q);
    if (out_reset) begin
      pop_ok             = 1'b0;
      rptr_d             = '0;
      rgray_d            = '0;
      out_nempty_d       = 1'b0;
      out_level_d        = '0;
      out_almost_empty_d = 1'b1;
      out_underflow_d    = 1'b0;
    end
  end

  always_ff @(posedge out_clock) begin
    rptr_q             <= rptr_d;
    rgray_q            <= rgray_d;
    out_nempty_q       <= out_nempty_d;
    out_level_q        <= out_level_d;
    out_almost_empty_q <= out_almost_empty_d;
    out_underflow_q    <= out_underflow_d;
  end

`ifdef FIFO_FWFT_EN
  // Fall-through: the output register prefetches the word at the next read
  // pointer on every edge, so the head word is already present when
  // out_nempty rises. A pop immediately fetches the following word. The
  // head slot is freed only when it is popped, so it is still counted in
  // out_level and cannot be overwritten while it is displayed.
  assign rd_addr = rptr_d[ABITS-1:0];
  assign rd_en   = 1'b1;
`else
  // Standard mode: the word at the current read pointer is loaded only on
  // an accepted pop, so out_data holds its value between pops.
  assign rd_addr = rptr_q[ABITS-1:0];
  assign rd_en   = pop_ok;
`endif

  // Synchronous read port with an output register. This form maps onto
  // block RAM.
  always_ff @(posedge out_clock) begin
    if (out_reset) begin
      out_data_q <= '0;
    end else if (rd_en) begin
      out_data_q <= ram[rd_addr];
    end
  end

  assign in_full          = in_full_q;
  assign in_almost_full   = in_almost_full_q;
  assign in_level         = in_level_q;
  assign in_overflow      = in_overflow_q;
  assign out_data         = out_data_q;
  assign out_nempty       = out_nempty_q;
  assign out_almost_empty = out_almost_empty_q;
  assign out_level        = out_level_q;
  assign out_underflow    = out_underflow_q;

endmodule

// File: tb/tb_fifo_gray_async.sv
// ---------------------------------------------------------------------------
// tb_fifo_gray_async
//   Directed bench for fifo_gray_async with WIDTH=8, DEPTH=8,
//   AFULL_THRESH=6, AEMPTY_THRESH=2, SYNC_STAGES=2. Read-data expectations
//   follow whichever output mode FIFO_FWFT_EN selects.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_gray_async;

  logic       in_clock;
  logic       out_clock;
  logic       reset;
  logic       in_shift;
  logic [7:0] in_data;
  logic       in_full;
  logic       in_almost_full;
  logic [3:0] in_level;
  logic       in_overflow;
  logic       out_pop;
  logic [7:0] out_data;
  logic       out_nempty;
  logic       out_almost_empty;
  logic [3:0] out_level;
  logic       out_underflow;

  int n_cmp = 0;
  int n_err = 0;

  int in_half  = 5;
  int out_half = 15;

  logic [7:0] sb_q [$];

  fifo_gray_async #(
    .WIDTH        (8),
    .DEPTH        (8),
    .AFULL_THRESH (6),
    .AEMPTY_THRESH(2),
    .SYNC_STAGES  (2)
  ) dut (
    .in_clock        (in_clock),
    .reset           (reset),
    .out_clock       (out_clock),
    .in_shift        (in_shift),
    .in_data         (in_data),
    .in_full         (in_full),
    .in_almost_full  (in_almost_full),
    .in_level        (in_level),
    .in_overflow     (in_overflow),
    .out_pop         (out_pop),
    .out_data        (out_data),
    .out_nempty      (out_nempty),
    .out_almost_empty(out_almost_empty),
    .out_level       (out_level),
    .out_underflow   (out_underflow)
  );

  // Write-side clock; its half period changes for the ratio test.
  initial begin
    in_clock = 1'b0;
    forever #(in_half) in_clock = ~in_clock;
  end

  // Read-side clock.
  initial begin
    out_clock = 1'b0;
    forever #(out_half) out_clock = ~out_clock;
  end

  // Hard stop if something hangs.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // One write request, driven between in_clock edges. Returns on the
  // negedge after the write edge.
  task automatic wr(input logic [7:0] d);
    @(negedge in_clock);
    in_shift = 1'b1;
    in_data  = d;
    @(negedge in_clock);
    in_shift = 1'b0;
  endtask

  // One pop request. Returns on the negedge after the pop edge.
  task automatic pop();
    @(negedge out_clock);
    out_pop = 1'b1;
    @(negedge out_clock);
    out_pop = 1'b0;
  endtask

  // Reset held for six slow-clock cycles, then time for the read side to
  // leave its synchronised reset.
  task automatic do_reset();
    @(negedge in_clock);
    reset = 1'b1;
    repeat (6) @(posedge out_clock);
    @(negedge in_clock);
    reset = 1'b0;
    repeat (5) @(negedge out_clock);
    repeat (2) @(negedge in_clock);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_full: got %b want 0", in_full); end
    n_cmp++; if (in_almost_full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_afull: got %b want 0", in_almost_full); end
    n_cmp++; if (in_level !== 4'd0) begin n_err++; $display("[TB] FAIL reset_in_level: got %0d want 0", in_level); end
    n_cmp++; if (in_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL reset_overflow: got %b want 0", in_overflow); end
    n_cmp++; if (out_nempty !== 1'b0) begin n_err++; $display("[TB] FAIL reset_nempty: got %b want 0", out_nempty); end
    n_cmp++; if (out_level !== 4'd0) begin n_err++; $display("[TB] FAIL reset_out_level: got %0d want 0", out_level); end
    n_cmp++; if (out_almost_empty !== 1'b1) begin n_err++; $display("[TB] FAIL reset_aempty: got %b want 1", out_almost_empty); end
    n_cmp++; if (out_underflow !== 1'b0) begin n_err++; $display("[TB] FAIL reset_underflow: got %b want 0", out_underflow); end
`ifndef FIFO_FWFT_EN
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr(8'(i));
      if (i == 7) begin
        n_cmp++; if (in_full !== 1'b0) begin n_err++; $display("[TB] FAIL fill_full_at7: got %b want 0", in_full); end
      end
    end
    n_cmp++; if (in_full !== 1'b1) begin n_err++; $display("[TB] FAIL fill_full_at8: got %b want 1", in_full); end
    n_cmp++; if (in_level !== 4'd8) begin n_err++; $display("[TB] FAIL fill_in_level: got %0d want 8", in_level); end
    repeat (4) @(negedge out_clock);
    n_cmp++; if (out_level !== 4'd8) begin n_err++; $display("[TB] FAIL fill_out_level: got %0d want 8", out_level); end
    n_cmp++; if (out_nempty !== 1'b1) begin n_err++; $display("[TB] FAIL fill_nempty: got %b want 1", out_nempty); end
  endtask

  task automatic test_overflow();
    wr(8'hAA);
    n_cmp++; if (in_overflow !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_set: got %b want 1", in_overflow); end
    n_cmp++; if (in_level !== 4'd8) begin n_err++; $display("[TB] FAIL ovf_level: got %0d want 8", in_level); end
    repeat (5) @(negedge in_clock);
    n_cmp++; if (in_overflow !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_sticky: got %b want 1", in_overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
      n_cmp++; if (out_data !== 8'(i)) begin n_err++; $display("[TB] FAIL drain_word%0d: got %h want %h", i, out_data, 8'(i)); end
      pop();
`else
      pop();
      n_cmp++; if (out_data !== 8'(i)) begin n_err++; $display("[TB] FAIL drain_word%0d: got %h want %h", i, out_data, 8'(i)); end
`endif
    end
    n_cmp++; if (out_nempty !== 1'b0) begin n_err++; $display("[TB] FAIL drain_nempty: got %b want 0", out_nempty); end
    n_cmp++; if (out_level !== 4'd0) begin n_err++; $display("[TB] FAIL drain_out_level: got %0d want 0", out_level); end
    repeat (6) @(negedge in_clock);
    n_cmp++; if (in_full !== 1'b0) begin n_err++; $display("[TB] FAIL drain_in_full: got %b want 0", in_full); end
    n_cmp++; if (in_level !== 4'd0) begin n_err++; $display("[TB] FAIL drain_in_level: got %0d want 0", in_level); end
  endtask

  task automatic test_underflow();
    pop();
    n_cmp++; if (out_underflow !== 1'b1) begin n_err++; $display("[TB] FAIL udf_set: got %b want 1", out_underflow); end
    n_cmp++; if (out_level !== 4'd0) begin n_err++; $display("[TB] FAIL udf_level: got %0d want 0", out_level); end
    // An unchanged read pointer means a new word is seen and read normally.
    wr(8'h33);
    repeat (4) @(negedge out_clock);
    n_cmp++; if (out_level !== 4'd1) begin n_err++; $display("[TB] FAIL udf_level_after_write: got %0d want 1", out_level); end
`ifdef FIFO_FWFT_EN
    n_cmp++; if (out_data !== 8'h33) begin n_err++; $display("[TB] FAIL udf_next_word: got %h want 33", out_data); end
    pop();
`else
    pop();
    n_cmp++; if (out_data !== 8'h33) begin n_err++; $display("[TB] FAIL udf_next_word: got %h want 33", out_data); end
`endif
    n_cmp++; if (out_underflow !== 1'b1) begin n_err++; $display("[TB] FAIL udf_sticky: got %b want 1", out_underflow); end
  endtask

  task automatic test_thresholds();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr(8'h10 + 8'(i));
      if (i == 4) begin
        n_cmp++; if (in_almost_full !== 1'b0) begin n_err++; $display("[TB] FAIL afull_at5: got %b want 0", in_almost_full); end
      end
    end
    n_cmp++; if (in_almost_full !== 1'b1) begin n_err++; $display("[TB] FAIL afull_at6: got %b want 1", in_almost_full); end
    repeat (4) @(negedge out_clock);
    n_cmp++; if (out_level !== 4'd6) begin n_err++; $display("[TB] FAIL thr_out_level6: got %0d want 6", out_level); end
    n_cmp++; if (out_almost_empty !== 1'b0) begin n_err++; $display("[TB] FAIL aempty_at6: got %b want 0", out_almost_empty); end
    repeat (3) pop();
    n_cmp++; if (out_level !== 4'd3) begin n_err++; $display("[TB] FAIL thr_out_level3: got %0d want 3", out_level); end
    n_cmp++; if (out_almost_empty !== 1'b0) begin n_err++; $display("[TB] FAIL aempty_at3: got %b want 0", out_almost_empty); end
    pop();
    n_cmp++; if (out_almost_empty !== 1'b1) begin n_err++; $display("[TB] FAIL aempty_at2: got %b want 1", out_almost_empty); end
    repeat (2) pop();
    repeat (6) @(negedge in_clock);
    n_cmp++; if (in_almost_full !== 1'b0) begin n_err++; $display("[TB] FAIL afull_after_drain: got %b want 0", in_almost_full); end
  endtask

  task automatic test_wrap_random();
    int         n_wr      = 0;
    int         n_rd      = 0;
    int         lvl_bad   = 0;
    logic [7:0] exp_word;
    in_half  = 3;
    out_half = 7;
    do_reset();
    sb_q.delete();
    fork
      begin : writer
        int wcyc = 0;
        while (n_wr < 1000 && wcyc < 40000) begin
          @(negedge in_clock);
          if (!in_full && $urandom_range(0, 1) == 1) begin
            in_shift = 1'b1;
            in_data  = 8'($urandom);
            sb_q.push_back(in_data);
            n_wr++;
          end else begin
            in_shift = 1'b0;
          end
          if (in_level > 4'd8) lvl_bad++;
          wcyc++;
        end
        @(negedge in_clock);
        in_shift = 1'b0;
      end
      begin : reader
        int   rcyc    = 0;
        logic pending = 1'b0;
        while ((n_rd < 1000 || pending) && rcyc < 40000) begin
          @(negedge out_clock);
          if (out_level > 4'd8) lvl_bad++;
`ifdef FIFO_FWFT_EN
          if (out_nempty && n_rd < 1000 && $urandom_range(0, 3) != 0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
              n_err++; $display("[TB] FAIL rand_word%0d: got %h with no word written", n_rd, out_data);
            end else begin
              exp_word = sb_q.pop_front();
              if (out_data !== exp_word) begin n_err++; $display("[TB] FAIL rand_word%0d: got %h want %h", n_rd, out_data, exp_word); end
            end
            out_pop = 1'b1;
            n_rd++;
          end else begin
            out_pop = 1'b0;
          end
`else
          if (pending) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
              n_err++; $display("[TB] FAIL rand_word%0d: got %h with no word written", n_rd, out_data);
            end else begin
              exp_word = sb_q.pop_front();
              if (out_data !== exp_word) begin n_err++; $display("[TB] FAIL rand_word%0d: got %h want %h", n_rd, out_data, exp_word); end
            end
            pending = 1'b0;
          end
          if (out_nempty && n_rd < 1000 && $urandom_range(0, 3) != 0) begin
            out_pop = 1'b1;
            pending = 1'b1;
            n_rd++;
          end else begin
            out_pop = 1'b0;
          end
`endif
          rcyc++;
        end
        out_pop = 1'b0;
      end
    join
    n_cmp++; if (n_rd !== 1000) begin n_err++; $display("[TB] FAIL rand_read_count: got %0d want 1000", n_rd); end
    n_cmp++; if (lvl_bad !== 0) begin n_err++; $display("[TB] FAIL rand_level_bound: got %0d samples above 8 want 0", lvl_bad); end
    repeat (5) @(negedge out_clock);
    n_cmp++; if (out_nempty !== 1'b0) begin n_err++; $display("[TB] FAIL rand_end_nempty: got %b want 0", out_nempty); end
    n_cmp++; if (in_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL rand_overflow: got %b want 0", in_overflow); end
    n_cmp++; if (out_underflow !== 1'b0) begin n_err++; $display("[TB] FAIL rand_underflow: got %b want 0", out_underflow); end
    n_cmp++; if (in_level !== 4'd0) begin n_err++; $display("[TB] FAIL rand_end_in_level: got %0d want 0", in_level); end
    in_half  = 5;
    out_half = 15;
    repeat (3) @(negedge out_clock);
  endtask

  task automatic test_reset_mid();
    pop();
    n_cmp++; if (out_underflow !== 1'b1) begin n_err++; $display("[TB] FAIL mid_udf_pre: got %b want 1", out_underflow); end
    for (int i = 0; i < 5; i++) wr(8'h61 + 8'(i));
    repeat (4) @(negedge out_clock);
    n_cmp++; if (out_level !== 4'd5) begin n_err++; $display("[TB] FAIL mid_level_pre: got %0d want 5", out_level); end
    do_reset();
    n_cmp++; if (in_level !== 4'd0) begin n_err++; $display("[TB] FAIL mid_in_level: got %0d want 0", in_level); end
    n_cmp++; if (out_level !== 4'd0) begin n_err++; $display("[TB] FAIL mid_out_level: got %0d want 0", out_level); end
    n_cmp++; if (in_full !== 1'b0) begin n_err++; $display("[TB] FAIL mid_in_full: got %b want 0", in_full); end
    n_cmp++; if (out_nempty !== 1'b0) begin n_err++; $display("[TB] FAIL mid_nempty: got %b want 0", out_nempty); end
    n_cmp++; if (in_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL mid_overflow: got %b want 0", in_overflow); end
    n_cmp++; if (out_underflow !== 1'b0) begin n_err++; $display("[TB] FAIL mid_underflow: got %b want 0", out_underflow); end
    wr(8'h55);
    repeat (4) @(negedge out_clock);
    n_cmp++; if (out_level !== 4'd1) begin n_err++; $display("[TB] FAIL mid_level_post: got %0d want 1", out_level); end
`ifdef FIFO_FWFT_EN
    n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("[TB] FAIL mid_first_word: got %h want 55", out_data); end
    pop();
`else
    pop();
    n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("[TB] FAIL mid_first_word: got %h want 55", out_data); end
`endif
    n_cmp++; if (out_nempty !== 1'b0) begin n_err++; $display("[TB] FAIL mid_end_nempty: got %b want 0", out_nempty); end
  endtask

  initial begin
    reset    = 1'b1;
    in_shift = 1'b0;
    in_data  = 8'h00;
    out_pop  = 1'b0;
    $display("[TB] fifo_gray_async bench start");
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_thresholds();
    test_wrap_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
